// File: rtl/light_monitor.sv
// Passive observer of the light pattern bus: tracks the generator's step sequence, classifies SHIFT speed, counts cycles.
// Optional bus watchdog enabled by defining LIGHT_MON_STUCK_DET_EN (adds STUCK_LIMIT parameter and drives `stuck`).
module light_monitor #(
  parameter int CNT_W       = 18,
  parameter int FAST_THRESH = 30000
`ifdef LIGHT_MON_STUCK_DET_EN
  , parameter int STUCK_LIMIT = 200000
`endif
) (
  input  logic       clk100khz,
  input  logic       rst_n,
  input  logic [7:0] light,
  output logic [1:0] phase,
  output logic       step_strobe,
  output logic       seq_err,
  output logic       speed_fast,
  output logic       speed_valid,
  output logic [7:0] cycle_cnt,
  output logic       stuck
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    FLASH = 2'd1,
    SHIFT = 2'd2,
    ALT   = 2'd3
  } phase_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [7:0]       light_s_q, light_p_q;
  logic             change;
  phase_e           phase_q;
  logic [3:0]       exp_q;
  logic [7:0]       exp_val;
  logic [CNT_W-1:0] intv_q;
  logic             step_strobe_q, seq_err_q, speed_fast_q, speed_valid_q;
  logic [7:0]       cycle_cnt_q;

`ifdef LIGHT_MON_STUCK_DET_EN
  localparam int IDLE_W = $clog2(STUCK_LIMIT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(STUCK_LIMIT - 1);
  logic [IDLE_W-1:0] idle_q;
  logic              stuck_q;
`endif

  assign change = (light_s_q != light_p_q);

  // exp_q indexes the next legal value; index 10 is the second 00 that leads into ALT.
  always_comb begin
    exp_val = 8'hFF;
    case (exp_q)
      4'd0:    exp_val = 8'hFF;
      4'd1:    exp_val = 8'h00;
      4'd2:    exp_val = 8'h80;
      4'd3:    exp_val = 8'h40;
      4'd4:    exp_val = 8'h20;
      4'd5:    exp_val = 8'h10;
      4'd6:    exp_val = 8'h08;
      4'd7:    exp_val = 8'h04;
      4'd8:    exp_val = 8'h02;
      4'd9:    exp_val = 8'h01;
      4'd10:   exp_val = 8'h00;
      4'd11:   exp_val = 8'hAA;
      4'd12:   exp_val = 8'h55;
      default: exp_val = 8'hFF;
    endcase
  end

  always_ff @(posedge clk100khz) begin
    if (!rst_n) begin
      light_s_q     <= 8'h00;
      light_p_q     <= 8'h00;
      phase_q       <= HUNT;
      exp_q         <= 4'd0;
      intv_q        <= '0;
      step_strobe_q <= 1'b0;
      seq_err_q     <= 1'b0;
      speed_fast_q  <= 1'b0;
      speed_valid_q <= 1'b0;
      cycle_cnt_q   <= 8'd0;
`ifdef LIGHT_MON_STUCK_DET_EN
      idle_q        <= '0;
      stuck_q       <= 1'b0;
`endif
    end else begin
      light_s_q     <= light;
      light_p_q     <= light_s_q;
      step_strobe_q <= 1'b0;
      seq_err_q     <= 1'b0;

      if (change) begin
        intv_q <= CNT_W'(1);
      end else if (intv_q != CNT_MAX) begin
        intv_q <= intv_q + 1'b1;
      end

      if (change) begin
        if (phase_q == HUNT) begin
          if (light_s_q == 8'hFF) begin
            step_strobe_q <= 1'b1;
            phase_q       <= FLASH;
            exp_q         <= 4'd1;
          end
        end else if (light_s_q == exp_val) begin
          step_strobe_q <= 1'b1;
          exp_q         <= (exp_q == 4'd12) ? 4'd0 : exp_q + 4'd1;
          case (exp_q)
            4'd0: begin
              phase_q     <= FLASH;
              exp_q       <= 4'd1;
              cycle_cnt_q <= cycle_cnt_q + 8'd1;
            end
            4'd1:    phase_q <= SHIFT;
            4'd10:   phase_q <= ALT;
            default: phase_q <= phase_q;
          endcase
          // Only SHIFT-to-SHIFT steps have a regular dwell worth measuring.
          if (exp_q >= 4'd3 && exp_q <= 4'd9) begin
            speed_fast_q  <= (32'(intv_q) < FAST_THRESH);
            speed_valid_q <= 1'b1;
          end
        end else begin
          seq_err_q <= 1'b1;
          if (light_s_q == 8'hFF) begin
            phase_q <= FLASH;
            exp_q   <= 4'd1;
          end else begin
            phase_q <= HUNT;
            exp_q   <= 4'd0;
          end
        end
      end

`ifdef LIGHT_MON_STUCK_DET_EN
      if (change) begin
        idle_q  <= '0;
        stuck_q <= 1'b0;
      end else if (!stuck_q) begin
        idle_q <= idle_q + 1'b1;
        if (idle_q == IDLE_LAST) begin
          stuck_q <= 1'b1;
          phase_q <= HUNT;
          exp_q   <= 4'd0;
        end
      end
`endif
    end
  end

  assign phase       = phase_q;
  assign step_strobe = step_strobe_q;
  assign seq_err     = seq_err_q;
  assign speed_fast  = speed_fast_q;
  assign speed_valid = speed_valid_q;
  assign cycle_cnt   = cycle_cnt_q;
`ifdef LIGHT_MON_STUCK_DET_EN
  assign stuck = stuck_q;
`else
  assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_light_monitor.sv
// Directed bench for light_monitor: legal cycles at two speeds, sequence errors, late start, counter wrap, reset, watchdog.
module tb_light_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] light = 8'h00;
  logic [1:0] phase;
  logic       step_strobe, seq_err, speed_fast, speed_valid, stuck;
  logic [7:0] cycle_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n_strobe = 0;
  int n_err    = 0;

  // Legal values following the initial FF, ending with the FF that closes the cycle.
  logic [7:0] body [13] = '{8'h00, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04,
                            8'h02, 8'h01, 8'h00, 8'hAA, 8'h55, 8'hFF};

  light_monitor #(
    .CNT_W(18),
    .FAST_THRESH(30)
`ifdef LIGHT_MON_STUCK_DET_EN
    , .STUCK_LIMIT(50)
`endif
  ) dut (
    .clk100khz  (clk),
    .rst_n      (rst_n),
    .light      (light),
    .phase      (phase),
    .step_strobe(step_strobe),
    .seq_err    (seq_err),
    .speed_fast (speed_fast),
    .speed_valid(speed_valid),
    .cycle_cnt  (cycle_cnt),
    .stuck      (stuck)
  );

  // Clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step_strobe === 1'b1) n_strobe++;
    if (seq_err === 1'b1) n_err++;
  end

  // Driver tasks
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] v, input int dwell);
    @(negedge clk);
    light = v;
    repeat (dwell - 1) @(negedge clk);
  endtask

  task automatic run_body(input int dwell);
    for (int i = 0; i < 13; i++) drive(body[i], dwell);
  endtask

  task automatic do_reset(input logic [7:0] v);
    @(negedge clk);
    rst_n = 1'b0;
    light = v;
    wait_n(3);
    rst_n = 1'b1;
  endtask

  // Tests
  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    light = 8'h5A;
    wait_n(3);
    n_tests++; if (phase !== 2'd0) begin n_fail++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    n_tests++; if (step_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b expected 0", step_strobe); end
    n_tests++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", seq_err); end
    n_tests++; if (speed_fast !== 1'b0) begin n_fail++; $display("FAIL reset_fast: got %b expected 0", speed_fast); end
    n_tests++; if (speed_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", speed_valid); end
    n_tests++; if (cycle_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cycle_cnt); end
    n_tests++; if (stuck !== 1'b0) begin n_fail++; $display("FAIL reset_stuck: got %b expected 0", stuck); end
    light = 8'h00;
    rst_n = 1'b1;
  endtask

  task automatic test_fast_cycle;
    int s0, e0;
    do_reset(8'h00);
    s0 = n_strobe; e0 = n_err;
    drive(8'hFF, 10);
    run_body(10);
    wait_n(3);
    n_tests++; if (n_strobe - s0 !== 14) begin n_fail++; $display("FAIL fast_strobes: got %0d expected 14", n_strobe - s0); end
    n_tests++; if (n_err - e0 !== 0) begin n_fail++; $display("FAIL fast_errs: got %0d expected 0", n_err - e0); end
    n_tests++; if (cycle_cnt !== 8'd1) begin n_fail++; $display("FAIL fast_cnt: got %0d expected 1", cycle_cnt); end
    n_tests++; if (phase !== 2'd1) begin n_fail++; $display("FAIL fast_phase: got %0d expected 1", phase); end
    n_tests++; if (speed_fast !== 1'b1) begin n_fail++; $display("FAIL fast_speed: got %b expected 1", speed_fast); end
    n_tests++; if (speed_valid !== 1'b1) begin n_fail++; $display("FAIL fast_valid: got %b expected 1", speed_valid); end
  endtask

  task automatic test_slow_cycle;
    int e0;
    do_reset(8'h00);
    e0 = n_err;
    drive(8'hFF, 40);
    run_body(40);
    wait_n(3);
    n_tests++; if (speed_fast !== 1'b0) begin n_fail++; $display("FAIL slow_speed: got %b expected 0", speed_fast); end
    n_tests++; if (speed_valid !== 1'b1) begin n_fail++; $display("FAIL slow_valid: got %b expected 1", speed_valid); end
    n_tests++; if (cycle_cnt !== 8'd1) begin n_fail++; $display("FAIL slow_cnt: got %0d expected 1", cycle_cnt); end
    n_tests++; if (phase !== 2'd1) begin n_fail++; $display("FAIL slow_phase: got %0d expected 1", phase); end
    drive(8'h00, 10);
    drive(8'h80, 10);
    drive(8'h40, 10);
    n_tests++; if (speed_fast !== 1'b1) begin n_fail++; $display("FAIL slow_to_fast: got %b expected 1", speed_fast); end
    wait_n(25);
    drive(8'h20, 4);
    n_tests++; if (speed_fast !== 1'b0) begin n_fail++; $display("FAIL fast_to_slow: got %b expected 0", speed_fast); end
    n_tests++; if (n_err - e0 !== 0) begin n_fail++; $display("FAIL slow_errs: got %0d expected 0", n_err - e0); end
  endtask

  task automatic test_skip_error;
    int s0, e0;
    do_reset(8'h00);
    drive(8'hFF, 5);
    drive(8'h00, 5);
    drive(8'h80, 5);
    e0 = n_err;
    @(negedge clk);
    light = 8'h20;
    @(negedge clk);
    n_tests++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL skip_err_early: got %b expected 0", seq_err); end
    @(negedge clk);
    n_tests++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL skip_err_pulse: got %b expected 1", seq_err); end
    n_tests++; if (step_strobe !== 1'b0) begin n_fail++; $display("FAIL skip_no_strobe: got %b expected 0", step_strobe); end
    n_tests++; if (phase !== 2'd0) begin n_fail++; $display("FAIL skip_phase: got %0d expected 0", phase); end
    @(negedge clk);
    n_tests++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL skip_err_len: got %b expected 0", seq_err); end
    s0 = n_strobe;
    drive(8'hFF, 5);
    n_tests++; if (phase !== 2'd1) begin n_fail++; $display("FAIL skip_resume_phase: got %0d expected 1", phase); end
    n_tests++; if (cycle_cnt !== 8'd0) begin n_fail++; $display("FAIL skip_resume_cnt: got %0d expected 0", cycle_cnt); end
    n_tests++; if (n_strobe - s0 !== 1) begin n_fail++; $display("FAIL skip_resume_strobe: got %0d expected 1", n_strobe - s0); end
    drive(8'h00, 5);
    drive(8'h80, 5);
    drive(8'hFF, 5);
    n_tests++; if (phase !== 2'd1) begin n_fail++; $display("FAIL resync_phase: got %0d expected 1", phase); end
    n_tests++; if (n_err - e0 !== 2) begin n_fail++; $display("FAIL resync_errs: got %0d expected 2", n_err - e0); end
    n_tests++; if (cycle_cnt !== 8'd0) begin n_fail++; $display("FAIL resync_cnt: got %0d expected 0", cycle_cnt); end
  endtask

  task automatic test_midcycle_start;
    int s0, e0;
    do_reset(8'h10);
    s0 = n_strobe; e0 = n_err;
    drive(8'h10, 5);
    for (int i = 5; i < 12; i++) drive(body[i], 5);
    wait_n(3);
    n_tests++; if (n_strobe - s0 !== 0) begin n_fail++; $display("FAIL late_strobes: got %0d expected 0", n_strobe - s0); end
    n_tests++; if (n_err - e0 !== 0) begin n_fail++; $display("FAIL late_errs: got %0d expected 0", n_err - e0); end
    n_tests++; if (phase !== 2'd0) begin n_fail++; $display("FAIL late_phase: got %0d expected 0", phase); end
    drive(8'hFF, 5);
    run_body(5);
    wait_n(3);
    n_tests++; if (n_strobe - s0 !== 14) begin n_fail++; $display("FAIL late_cycle_strobes: got %0d expected 14", n_strobe - s0); end
    n_tests++; if (cycle_cnt !== 8'd1) begin n_fail++; $display("FAIL late_cycle_cnt: got %0d expected 1", cycle_cnt); end
    n_tests++; if (n_err - e0 !== 0) begin n_fail++; $display("FAIL late_cycle_errs: got %0d expected 0", n_err - e0); end
  endtask

  task automatic test_wrap_and_reset;
    int s0, e0;
    do_reset(8'h00);
    e0 = n_err;
    drive(8'hFF, 2);
    for (int c = 0; c < 255; c++) run_body(2);
    wait_n(3);
    n_tests++; if (cycle_cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d expected 255", cycle_cnt); end
    run_body(2);
    wait_n(3);
    n_tests++; if (cycle_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_0: got %0d expected 0", cycle_cnt); end
    n_tests++; if (n_err - e0 !== 0) begin n_fail++; $display("FAIL wrap_errs: got %0d expected 0", n_err - e0); end
    drive(8'h00, 2);
    drive(8'h80, 2);
    drive(8'h40, 2);
    wait_n(2);
    n_tests++; if (phase !== 2'd2) begin n_fail++; $display("FAIL mid_shift_phase: got %0d expected 2", phase); end
    n_tests++; if (speed_valid !== 1'b1) begin n_fail++; $display("FAIL mid_shift_valid: got %b expected 1", speed_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++; if (phase !== 2'd0) begin n_fail++; $display("FAIL rst_phase: got %0d expected 0", phase); end
    n_tests++; if (cycle_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d expected 0", cycle_cnt); end
    n_tests++; if (speed_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", speed_valid); end
    n_tests++; if (speed_fast !== 1'b0) begin n_fail++; $display("FAIL rst_fast: got %b expected 0", speed_fast); end
    rst_n = 1'b1;
    s0 = n_strobe;
    wait_n(5);
    n_tests++; if (n_strobe - s0 !== 0) begin n_fail++; $display("FAIL rst_no_strobe: got %0d expected 0", n_strobe - s0); end
    n_tests++; if (phase !== 2'd0) begin n_fail++; $display("FAIL rst_hunt: got %0d expected 0", phase); end
  endtask

  task automatic test_stuck;
    int e0;
    logic [1:0] exp_phase;
    logic       exp_stuck;
    int         exp_err;
    do_reset(8'h00);
    drive(8'hFF, 5);
    drive(8'h00, 5);
    drive(8'h80, 5);
    e0 = n_err;
    drive(8'h40, 60);
`ifdef LIGHT_MON_STUCK_DET_EN
    exp_phase = 2'd0; exp_stuck = 1'b1; exp_err = 0;
`else
    exp_phase = 2'd2; exp_stuck = 1'b0; exp_err = 1;
`endif
    n_tests++; if (stuck !== exp_stuck) begin n_fail++; $display("FAIL stuck_set: got %b expected %b", stuck, exp_stuck); end
    n_tests++; if (phase !== exp_phase) begin n_fail++; $display("FAIL stuck_phase: got %0d expected %0d", phase, exp_phase); end
    n_tests++; if (n_err - e0 !== 0) begin n_fail++; $display("FAIL stuck_no_err: got %0d expected 0", n_err - e0); end
    drive(8'hFF, 5);
    n_tests++; if (stuck !== 1'b0) begin n_fail++; $display("FAIL stuck_clear: got %b expected 0", stuck); end
    n_tests++; if (phase !== 2'd1) begin n_fail++; $display("FAIL stuck_resume: got %0d expected 1", phase); end
    n_tests++; if (n_err - e0 !== exp_err) begin n_fail++; $display("FAIL stuck_resume_err: got %0d expected %0d", n_err - e0, exp_err); end
  endtask

  initial begin
    test_reset();
    test_fast_cycle();
    test_slow_cycle();
    test_skip_error();
    test_midcycle_start();
    test_wrap_and_reset();
    test_stuck();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
